// File: rtl/rv_alu.sv
// RV32I integer ALU: result y selected by {instr[30], funct3}, branch flag from funct3.
// Define ALU_OUT_REG_EN to register both outputs (1-cycle latency, sync reset to 0).
module rv_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rts,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             cmp_flag
);

  logic [WIDTH-1:0] y_d;
  logic             cmp_d;
  logic [4:0]       shamt;
  logic             eq;
  logic             lt_s;
  logic             lt_u;

  assign shamt = b[4:0];
  assign eq    = (a == b);
  assign lt_s  = ($signed(a) < $signed(b));
  assign lt_u  = (a < b);

  always_comb begin
    y_d = '0;
    unique case (alu_op[2:0])
      3'b000:  y_d = alu_op[3] ? (a - b) : (a + b);
      3'b001:  y_d = a << shamt;
      3'b010:  y_d = {{(WIDTH-1){1'b0}}, lt_s};
      3'b011:  y_d = {{(WIDTH-1){1'b0}}, lt_u};
      3'b100:  y_d = a ^ b;
      3'b101:  y_d = alu_op[3] ? WIDTH'($signed(a) >>> shamt) : (a >> shamt);
      3'b110:  y_d = a | b;
      3'b111:  y_d = a & b;
      default: y_d = '0;
    endcase
  end

  // Bit 3 is ignored: branch immediates set instr[30] arbitrarily.
  always_comb begin
    cmp_d = 1'b0;
    unique case (alu_op[2:0])
      3'b000:  cmp_d = eq;
      3'b001:  cmp_d = ~eq;
      3'b100:  cmp_d = lt_s;
      3'b101:  cmp_d = ~lt_s;
      3'b110:  cmp_d = lt_u;
      3'b111:  cmp_d = ~lt_u;
      default: cmp_d = 1'b0;
    endcase
  end

`ifdef ALU_OUT_REG_EN
  logic [WIDTH-1:0] y_q;
  logic             cmp_q;

  always_ff @(posedge clk) begin
    if (rts) begin
      y_q   <= '0;
      cmp_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      cmp_q <= cmp_d;
    end
  end

  assign y        = y_q;
  assign cmp_flag = cmp_q;
`else
  logic unused_clk_rts;
  assign unused_clk_rts = clk ^ rts;

  assign y        = y_d;
  assign cmp_flag = cmp_d;
`endif

endmodule

// File: tb/tb_rv_alu.sv
// Directed self-checking bench for rv_alu; covers both the combinational and
// the ALU_OUT_REG_EN registered build.
module tb_rv_alu;

  logic        clk;
  logic        rts;
  logic [3:0]  alu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] y;
  logic        cmp_flag;

  int tests;
  int fails;

  rv_alu #(.WIDTH(32)) dut (
    .clk      (clk),
    .rts      (rts),
    .alu_op   (alu_op),
    .a        (a),
    .b        (b),
    .y        (y),
    .cmp_flag (cmp_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_result();
`ifdef ALU_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic check(input string tag, input logic [31:0] exp_y, input logic exp_cmp);
    tests++;
    assert (y === exp_y) else begin
      fails++;
      $error("FAIL %s y: observed=%08h expected=%08h", tag, y, exp_y);
    end
    tests++;
    assert (cmp_flag === exp_cmp) else begin
      fails++;
      $error("FAIL %s cmp: observed=%0b expected=%0b", tag, cmp_flag, exp_cmp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] op, input logic [31:0] va,
                      input logic [31:0] vb, input logic [31:0] exp_y, input logic exp_cmp);
    @(negedge clk);
    rts    = 1'b0;
    alu_op = op;
    a      = va;
    b      = vb;
    wait_result();
    check(tag, exp_y, exp_cmp);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rts    = 1'b1;
    alu_op = 4'b0000;
    a      = 32'h1234_5678;
    b      = 32'h9abc_def0;

`ifdef ALU_OUT_REG_EN
    @(negedge clk);
    rts = 1'b1;
    @(posedge clk);
    #1;
    check("reset", 32'h0, 1'b0);
    step("reg_add", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0);
    @(negedge clk);
    rts    = 1'b1;
    alu_op = 4'b0110;
    a      = 32'hFFFF_FFFF;
    b      = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    check("reset_overrides_op", 32'h0, 1'b0);
    step("after_reset", 4'b0110, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0);
`endif

    // Arithmetic wrap
    step("add_wrap",  4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0,         1'b0);
    step("sub_wrap",  4'b1000, 32'h0,         32'h1, 32'hFFFF_FFFF, 1'b0);
    step("sub_neg",   4'b1000, 32'd5,         32'd7, 32'hFFFF_FFFE, 1'b0);

    // Shifts, only b[4:0] matters
    step("srl",       4'b0101, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0);
    step("sra",       4'b1101, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0);
    step("sll31",     4'b0001, 32'h1,         32'd31, 32'h8000_0000, 1'b1);
    step("sll_b3",    4'b1001, 32'h1, 32'hFFFF_FFE1,  32'h2,         1'b1);
    step("sra_pos",   4'b1101, 32'h7FFF_FFFF, 32'h1F, 32'h0,         1'b1);
    step("srl31",     4'b0101, 32'h8000_0000, 32'h1F, 32'h1,         1'b0);
    step("sra_sh0",   4'b1101, 32'h8000_0000, 32'h20, 32'h8000_0000, 1'b0);

    // SLT/SLTU
    step("slt",       4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);
    step("sltu",      4'b0011, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    step("sltu_b3",   4'b1011, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    step("slt_b3",    4'b1010, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0);
    step("sltu_true", 4'b0011, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b0);

    // Branch flags with a=-1, b=1
    step("blt",       4'b0100, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 1'b1);
    step("bge",       4'b0101, 32'hFFFF_FFFF, 32'h1, 32'h7FFF_FFFF, 1'b0);
    step("bltu",      4'b0110, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 1'b0);
    step("bgeu",      4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h0000_0001, 1'b1);
    step("blt_b3",    4'b1100, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 1'b1);
    step("bgeu_b3",   4'b1111, 32'hFFFF_FFFF, 32'h1, 32'h0000_0001, 1'b1);

    // Equality
    step("beq",       4'b0000, 32'd5, 32'd5, 32'd10,   1'b1);
    step("bne",       4'b1001, 32'd5, 32'd5, 32'h0A0,  1'b0);
    step("beq_b3",    4'b1000, 32'd5, 32'd5, 32'h0,    1'b1);

    // Logic ops, bit 3 clear and set
    step("xor",       4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b1);
    step("or",        4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0);
    step("and",       4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b1);
    step("xor_b3",    4'b1100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b1);
    step("or_b3",     4'b1110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0);
    step("and_b3",    4'b1111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
